// File: rtl/gpio_apb_sequencer.sv
// APB master for the board GPIO core: programs every CONFIG_n register after reset,
// then merges masked LED updates from two requesters into GPIO_OUT writes.
// Optional GPIO_IN polling is enabled by defining GPIO_SEQ_POLL_EN.
module gpio_apb_sequencer #(
  parameter int unsigned IO_NUM      = 3,
  parameter logic [31:0] CFG_WORD    = 32'h0000_0005,
  parameter logic [7:0]  OUT_ADDR    = 8'hA0,
  parameter logic [7:0]  IN_ADDR     = 8'h90,
  parameter int unsigned POLL_PERIOD = 1024
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [1:0]        req_valid,
  input  logic [IO_NUM-1:0] req_data0,
  input  logic [IO_NUM-1:0] req_data1,
  input  logic [IO_NUM-1:0] req_mask0,
  input  logic [IO_NUM-1:0] req_mask1,
  output logic [1:0]        req_ack,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [7:0]        PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              cfg_done,
  output logic [IO_NUM-1:0] gpio_out_q,
  output logic [IO_NUM-1:0] gpio_in_q,
  output logic              bus_err
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {
    CFG_SETUP,
    CFG_ACCESS,
    IDLE,
    WR_SETUP,
    WR_ACCESS
`ifdef GPIO_SEQ_POLL_EN
    ,
    RD_SETUP,
    RD_ACCESS
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_last;
  logic              last_grant;
  logic              wr_sel;
  logic              wr_start;
  logic              grant_sel;
  logic [1:0]        elig;
  logic [IO_NUM-1:0] new_c;
  logic              done_c;
  logic              psel_d, penable_d, pwrite_d;
  logic              unused_rd;

  // PENABLE is high only in ACCESS, so this marks the completing cycle of any transfer
  assign done_c    = PENABLE && PREADY;
  assign cfg_last  = (cfg_idx == IDX_W'(IO_NUM - 1));
  assign unused_rd = ^PRDATA;

`ifdef GPIO_SEQ_POLL_EN
  localparam int unsigned CNT_W = $clog2(POLL_PERIOD);

  logic [CNT_W-1:0] poll_cnt;
  logic             poll_pending;
  logic             poll_tick_c;
  logic             rd_start;

  assign poll_tick_c = cfg_done && (poll_cnt == CNT_W'(POLL_PERIOD - 1));

  // Free-running poll timer; an expiry while a poll is still pending is simply absorbed
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
      gpio_in_q    <= '0;
    end else begin
      if (!cfg_done || poll_tick_c) poll_cnt <= '0;
      else                          poll_cnt <= poll_cnt + CNT_W'(1);
      if (poll_tick_c)                            poll_pending <= 1'b1;
      else if (done_c && (state_q == RD_ACCESS))  poll_pending <= 1'b0;
      if (done_c && (state_q == RD_ACCESS)) gpio_in_q <= PRDATA[IO_NUM-1:0];
    end
  end
`else
  logic unused_poll;

  assign gpio_in_q   = '0;
  assign unused_poll = ^{IN_ADDR, 32'(POLL_PERIOD)};
`endif

  // Next-state, grant selection and next bus-phase controls
  always_comb begin
    state_d   = state_q;
    wr_start  = 1'b0;
`ifdef GPIO_SEQ_POLL_EN
    rd_start  = 1'b0;
`endif
    // a requester being acked this cycle has not yet had the chance to drop req_valid
    elig      = req_valid & ~req_ack;
    grant_sel = (elig == 2'b11) ? ~last_grant : elig[1];
    new_c     = grant_sel ? ((gpio_out_q & ~req_mask1) | (req_data1 & req_mask1))
                          : ((gpio_out_q & ~req_mask0) | (req_data0 & req_mask0));

    case (state_q)
      // right after reset PSEL is still low, so the SETUP phase is launched first
      CFG_SETUP:  if (PSEL) state_d = CFG_ACCESS;
      CFG_ACCESS: if (PREADY) state_d = IDLE;
      IDLE: begin
        if (!cfg_done) begin
          state_d = CFG_SETUP;
        end
`ifdef GPIO_SEQ_POLL_EN
        else if (poll_pending) begin
          state_d  = RD_SETUP;
          rd_start = 1'b1;
        end
`endif
        else if (elig != 2'b00) begin
          state_d  = WR_SETUP;
          wr_start = 1'b1;
        end
      end
      WR_SETUP:   state_d = WR_ACCESS;
      WR_ACCESS:  if (PREADY) state_d = IDLE;
`ifdef GPIO_SEQ_POLL_EN
      RD_SETUP:   state_d = RD_ACCESS;
      RD_ACCESS:  if (PREADY) state_d = IDLE;
`endif
      default:    state_d = CFG_SETUP;
    endcase

    psel_d    = 1'b1;
    penable_d = 1'b0;
    pwrite_d  = 1'b1;
    case (state_d)
      IDLE: begin
        psel_d   = 1'b0;
        pwrite_d = 1'b0;
      end
      CFG_ACCESS, WR_ACCESS: penable_d = 1'b1;
`ifdef GPIO_SEQ_POLL_EN
      RD_SETUP:  pwrite_d = 1'b0;
      RD_ACCESS: begin
        penable_d = 1'b1;
        pwrite_d  = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // State register and registered APB / status outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= CFG_SETUP;
      cfg_idx    <= '0;
      cfg_done   <= 1'b0;
      last_grant <= 1'b1;
      wr_sel     <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      req_ack    <= '0;
      gpio_out_q <= '0;
      bus_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      req_ack <= 2'b00;
      if (state_d == CFG_SETUP) begin
        PADDR  <= {1'b0, cfg_idx, 2'b00};
        PWDATA <= CFG_WORD;
      end
      if (wr_start) begin
        PADDR      <= OUT_ADDR;
        PWDATA     <= 32'(new_c);
        wr_sel     <= grant_sel;
        last_grant <= grant_sel;
      end
`ifdef GPIO_SEQ_POLL_EN
      if (rd_start) PADDR <= IN_ADDR;
`endif
      if (done_c) begin
        if (PSLVERR) bus_err <= 1'b1;
        case (state_q)
          CFG_ACCESS: begin
            if (cfg_last) cfg_done <= 1'b1;
            else          cfg_idx  <= cfg_idx + IDX_W'(1);
          end
          // the shadow follows the completed write even when the completer flagged an error
          WR_ACCESS: begin
            gpio_out_q <= PWDATA[IO_NUM-1:0];
            req_ack    <= wr_sel ? 2'b10 : 2'b01;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_apb_sequencer.sv
// Directed self-checking bench for gpio_apb_sequencer (IO_NUM = 3) with a scripted APB completer.
module tb_gpio_apb_sequencer;

`ifdef GPIO_SEQ_POLL_EN
  localparam int unsigned POLL_P = 16;
`else
  localparam int unsigned POLL_P = 1024;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [2:0]  req_data0, req_data1, req_mask0, req_mask1;
  logic [1:0]  req_ack;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        cfg_done;
  logic [2:0]  gpio_out_q, gpio_in_q;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  gpio_apb_sequencer #(.IO_NUM(3), .POLL_PERIOD(POLL_P)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_mask0(req_mask0), .req_mask1(req_mask1), .req_ack(req_ack),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_done(cfg_done), .gpio_out_q(gpio_out_q), .gpio_in_q(gpio_in_q),
    .bus_err(bus_err)
  );

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req_valid = 2'b00;
    req_data0 = '0; req_data1 = '0; req_mask0 = '0; req_mask1 = '0;
    PRDATA = 32'h2; PREADY = 1'b1; PSLVERR = 1'b0;
    step(); step();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 43'd0) begin
      failures++; $display("FAIL reset_bus got=%0h exp=0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA});
    end
    checks++;
    if ({req_ack, cfg_done, gpio_out_q, gpio_in_q, bus_err} !== 10'd0) begin
      failures++; $display("FAIL reset_status got=%0h exp=0", {req_ack, cfg_done, gpio_out_q, gpio_in_q, bus_err});
    end
  endtask

  task automatic test_config();
    int  n_wr, n_psel;
    bit  done, prev_access;
    n_wr = 0; n_psel = 0; done = 1'b0; prev_access = 1'b0;
    req_data0 = 3'b111; req_mask0 = 3'b111; req_valid = 2'b01;
    PRESET = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (cfg_done) begin
        done = 1'b1;
        req_valid = 2'b00;
        checks++;
        if (prev_access !== 1'b1) begin
          failures++; $display("FAIL cfg_done_timing got=%0b exp=1", prev_access);
        end
      end else begin
        if (PSEL) n_psel++;
        if (PSEL && !PENABLE) begin
          checks++;
          if ({PWRITE, PADDR, PWDATA} !== {1'b1, 8'(4 * n_wr), 32'h5}) begin
            failures++; $display("FAIL cfg_write%0d got=%0h exp=%0h", n_wr, {PWRITE, PADDR, PWDATA}, {1'b1, 8'(4 * n_wr), 32'h5});
          end
          n_wr++;
        end
        checks++;
        if (req_ack !== 2'b00) begin
          failures++; $display("FAIL cfg_req_ignored got=%0b exp=0", req_ack);
        end
        prev_access = PSEL && PENABLE;
      end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL cfg_timeout got=0 exp=1"); end
    checks++;
    if (n_wr != 3) begin failures++; $display("FAIL cfg_count got=%0d exp=3", n_wr); end
    checks++;
    if (n_psel != 6) begin failures++; $display("FAIL cfg_psel_cycles got=%0d exp=6", n_psel); end
  endtask

  task automatic test_both();
    step();
    req_data0 = 3'b001; req_mask0 = 3'b001; req_data1 = 3'b110; req_mask1 = 3'b110;
    req_valid = 2'b11;
    step();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 8'hA0, 32'h1}) begin
      failures++; $display("FAIL both_first_setup got=%0h exp=%0h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 8'hA0, 32'h1});
    end
    step();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL both_first_access got=%0b exp=11", {PSEL, PENABLE}); end
    step();
    checks++;
    if ({req_ack, gpio_out_q} !== {2'b01, 3'b001}) begin
      failures++; $display("FAIL both_first_ack got=%0b exp=01001", {req_ack, gpio_out_q});
    end
    req_valid = 2'b10;
    step();
    checks++;
    if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b10, 8'hA0, 32'h7}) begin
      failures++; $display("FAIL both_second_setup got=%0h exp=%0h", {PSEL, PENABLE, PADDR, PWDATA}, {2'b10, 8'hA0, 32'h7});
    end
    step(); step();
    checks++;
    if ({req_ack, gpio_out_q} !== {2'b10, 3'b111}) begin
      failures++; $display("FAIL both_second_ack got=%0b exp=10111", {req_ack, gpio_out_q});
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    step();
    req_data0 = 3'b101; req_mask0 = 3'b111; req_valid = 2'b01;
    step();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ack} !== {3'b101, 8'hA0, 32'h5, 2'b00}) begin
      failures++; $display("FAIL single_setup got=%0h exp=%0h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ack}, {3'b101, 8'hA0, 32'h5, 2'b00});
    end
    step(); step();
    checks++;
    if ({req_ack, gpio_out_q, PSEL} !== {2'b01, 3'b101, 1'b0}) begin
      failures++; $display("FAIL single_ack got=%0b exp=011010", {req_ack, gpio_out_q, PSEL});
    end
    req_valid = 2'b00;
    step();
    checks++;
    if ({req_ack, PSEL} !== 3'b000) begin failures++; $display("FAIL single_ack_pulse got=%0b exp=000", {req_ack, PSEL}); end
  endtask

  task automatic test_wait_err();
    step();
    PREADY = 1'b0;
    req_data1 = 3'b010; req_mask1 = 3'b011; req_valid = 2'b10;
    step();
    checks++;
    if ({PSEL, PENABLE, PADDR, PWDATA} !== {2'b10, 8'hA0, 32'h6}) begin
      failures++; $display("FAIL wait_setup got=%0h exp=%0h", {PSEL, PENABLE, PADDR, PWDATA}, {2'b10, 8'hA0, 32'h6});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, bus_err, req_ack} !== {3'b111, 8'hA0, 32'h6, 3'b000}) begin
        failures++; $display("FAIL wait_access%0d got=%0h exp=%0h", i, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, bus_err, req_ack}, {3'b111, 8'hA0, 32'h6, 3'b000});
      end
      if (i == 4) begin PREADY = 1'b1; PSLVERR = 1'b1; end
    end
    step();
    PSLVERR = 1'b0;
    checks++;
    if ({req_ack, bus_err, gpio_out_q, PSEL} !== {2'b10, 1'b1, 3'b110, 1'b0}) begin
      failures++; $display("FAIL wait_err_done got=%0b exp=1011100", {req_ack, bus_err, gpio_out_q, PSEL});
    end
    req_valid = 2'b00;
  endtask

  task automatic test_mask_zero();
    step();
    req_data0 = 3'b111; req_mask0 = 3'b000; req_valid = 2'b01;
    step();
    checks++;
    if ({PSEL, PWRITE, PADDR, PWDATA} !== {2'b11, 8'hA0, 32'h6}) begin
      failures++; $display("FAIL mask0_setup got=%0h exp=%0h", {PSEL, PWRITE, PADDR, PWDATA}, {2'b11, 8'hA0, 32'h6});
    end
    step(); step();
    checks++;
    if ({req_ack, gpio_out_q} !== {2'b01, 3'b110}) begin
      failures++; $display("FAIL mask0_ack got=%0b exp=01110", {req_ack, gpio_out_q});
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    step();
    PREADY = 1'b0;
    req_data1 = 3'b001; req_mask1 = 3'b001; req_valid = 2'b10;
    step(); step();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin failures++; $display("FAIL rstmid_access got=%0b exp=11", {PSEL, PENABLE}); end
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, req_ack} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_drop got=%0b exp=0000", {PSEL, PENABLE, req_ack});
    end
    checks++;
    if ({gpio_out_q, cfg_done, bus_err} !== 5'b00000) begin
      failures++; $display("FAIL rstmid_status got=%0b exp=00000", {gpio_out_q, cfg_done, bus_err});
    end
    req_valid = 2'b00; PREADY = 1'b1;
    step();
    test_config();
    checks++;
    if (gpio_out_q !== 3'b000) begin failures++; $display("FAIL rstmid_shadow got=%0b exp=000", gpio_out_q); end
  endtask

`ifdef GPIO_SEQ_POLL_EN
  task automatic test_poll();
    bit found;
    int n;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (PSEL && !PENABLE && !PWRITE) found = 1'b1;
    end
    checks++;
    if (!found || PADDR !== 8'h90) begin
      failures++; $display("FAIL poll_read got=%0h exp=90 found=%0b", PADDR, found);
    end
    req_data0 = 3'b111; req_mask0 = 3'b111; req_valid = 2'b01;
    step();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b110) begin failures++; $display("FAIL poll_access got=%0b exp=110", {PSEL, PENABLE, PWRITE}); end
    step();
    checks++;
    if ({gpio_in_q, PSEL} !== {3'b010, 1'b0}) begin failures++; $display("FAIL poll_latch got=%0b exp=0100", {gpio_in_q, PSEL}); end
    step();
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 8'hA0, 32'h7}) begin
      failures++; $display("FAIL poll_then_write got=%0h exp=%0h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 8'hA0, 32'h7});
    end
    step(); step();
    checks++;
    if (req_ack !== 2'b01) begin failures++; $display("FAIL poll_write_ack got=%0b exp=01", req_ack); end
    req_valid = 2'b00;
    n = 5; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      n++;
      if (PSEL && !PENABLE && !PWRITE) found = 1'b1;
    end
    checks++;
    if (!found || n != 16) begin failures++; $display("FAIL poll_period got=%0d exp=16 found=%0b", n, found); end
  endtask
`endif

  initial begin
    test_reset();
    test_config();
`ifdef GPIO_SEQ_POLL_EN
    test_poll();
`else
    test_both();
    test_single();
    test_wait_err();
    test_mask_zero();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_apb_sequencer.md
# gpio_apb_sequencer

APB master that owns the APB port of the board GPIO core and shares it between two LED-update requesters. After reset it programs the per-IO CONFIG registers, then merges masked output updates from requester 0 and requester 1 into a shadow image. Each update is issued as one APB write to the GPIO_OUT register. It sits between the game logic and the GPIO core, in place of a direct processor-bus connection.

## Interface
Parameters:
- IO_NUM, 3, number of GPIO bits driven (1..32)
- CFG_WORD, 32'h0000_0005, value written to every CONFIG_n register (output reg enable + output buffer enable)
- OUT_ADDR, 8'hA0, GPIO_OUT register offset
- IN_ADDR, 8'h90, GPIO_IN register offset (used only with polling)
- POLL_PERIOD, 1024, cycles between GPIO_IN polls (≥ 8)

Ports (one clock; reset is asynchronous and active-high):
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester update request, held until ack
- req_data0 / req_data1  in  IO_NUM  new output values
- req_mask0 / req_mask1  in  IO_NUM  bits the requester is allowed to change
- req_ack  out  2  one-cycle pulse when that requester's write has completed
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  8  APB address
- PWDATA  out  32  APB write data; bits above IO_NUM are 0
- PRDATA  in  32  APB read data
- PREADY, PSLVERR  in  1  APB completer response
- cfg_done  out  1  high once configuration is finished
- gpio_out_q  out  IO_NUM  current shadow image
- gpio_in_q  out  IO_NUM  last polled GPIO_IN value
- bus_err  out  1  sticky; set by any PSLVERR

## Operation
- States: CFG_SETUP, CFG_ACCESS, IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS.
- Reset enters CFG_SETUP with the index n = 0.
- CFG: write CFG_WORD to address 4·n for n = 0..IO_NUM-1, one APB write per n.
  - After the last write completes, go to IDLE and set cfg_done.
  - Requests are ignored (not acked) until cfg_done is high.
- IDLE grant order:
  - A pending poll is served first.
  - Otherwise, a valid requester is granted round-robin. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- On grant: new = (shadow & ~mask) | (data & mask), using the granted requester's data and mask.
  - new is registered as PWDATA, with PADDR = OUT_ADDR.
  - The shadow updates when the write completes, even if PSLVERR is set.
- req_ack pulses for the granted requester in the cycle after the ACCESS cycle that has PREADY = 1.
- The same requester holding req_valid is re-eligible only after the round-robin pointer passes it.
- Mask bit 0 leaves that shadow bit unchanged. A mask of all zeros still produces a full APB write.

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE = 0; PADDR = 0; PWDATA = 0.
  - req_ack = 0; cfg_done = 0; gpio_out_q = 0; gpio_in_q = 0; bus_err = 0.
- Reset is asynchronous: asserting PRESET mid-transfer drops PSEL/PENABLE in the same instant and restarts configuration.
- APB transfer:
  - SETUP cycle: PSEL = 1, PENABLE = 0.
  - ACCESS cycles: PSEL = 1, PENABLE = 1, held with PADDR/PWDATA/PWRITE stable until PREADY = 1.
  - Next cycle is IDLE (PSEL = 0); transfers are never back-to-back.
- Latency:
  - req_valid high in IDLE → SETUP on the next edge.
  - With zero-wait PREADY, req_ack is high 3 cycles after req_valid is first sampled.
- Configuration with IO_NUM = 3 and zero wait states takes 6 cycles of APB activity plus 2 idle gaps. cfg_done rises on the cycle after the last ACCESS.
- PSLVERR is sampled only in ACCESS with PREADY = 1. It sets bus_err, and the sequence continues.

## Configuration
- GPIO_SEQ_POLL_EN defined:
  - A free-running counter sets poll_pending every POLL_PERIOD cycles after cfg_done.
  - In IDLE, the pending poll is served as an APB read of IN_ADDR.
  - PRDATA[IO_NUM-1:0] is latched into gpio_in_q when the read completes, and poll_pending is cleared.
  - A period expiring while a poll is already pending is dropped, not queued.
- Not defined:
  - RD states, the counter and poll_pending are absent.
  - gpio_in_q is tied to 0 and IN_ADDR is unused.
  - PWRITE is 1 whenever PSEL is 1.

## Test plan
- Reset, zero-wait completer, IO_NUM = 3 → writes of 0x5 to 0x00, 0x04, 0x08 in order; cfg_done high after the third.
- After config, req0: data = 3'b101, mask = 3'b111 → PADDR = 0xA0, PWDATA = 0x5; req_ack[0] 3 cycles later; gpio_out_q = 3'b101.
- Both requesters valid in the same cycle (req0 data 3'b001 mask 3'b001, req1 data 3'b110 mask 3'b110) → req0 served first, then req1; final PWDATA = 0x7.
- Completer inserts 4 wait states and PSLVERR = 1 on the last → PADDR/PWDATA stable for 5 ACCESS cycles; bus_err = 1; shadow still updated; req_ack pulses.
- PRESET asserted during WR_ACCESS → PSEL = 0 immediately; configuration sequence restarts; gpio_out_q = 0; no req_ack.
- With GPIO_SEQ_POLL_EN, POLL_PERIOD = 16, PRDATA = 0x2 → a read of 0x90 every 16 cycles; gpio_in_q = 3'b010; a request arriving in the same cycle is served immediately after the poll.
